// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous instruction buffer; flush has priority over push/pop.
module fetch_unit_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == FULL_CNT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem reads, redirect squash and drain.
// Define FETCH_PERF_CNT_EN to add saturating fetched/squashed word counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    fetch_state_e  r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_pc_tag;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_outstanding_d;
    logic [CW-1:0] w_drop_next;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_credit_sum;
    logic [63:0]   w_fifo_head;
    logic [31:0]   w_target;
    logic          w_redirect, w_dropping, w_push, w_pop;
    logic          w_req_valid, w_accept, w_fifo_empty, w_fifo_full;

    assign w_target     = word_align(redirect_pc);
    assign w_redirect   = redirect_valid && (r_state != FS_IDLE);
    assign w_dropping   = imem_rsp_valid && (r_drop_cnt != '0);
    // A response landing in a redirect cycle is wrong-path even if it was not counted for drop.
    assign w_push       = imem_rsp_valid && !w_dropping && !w_redirect;
    assign w_pop        = !w_fifo_empty && id_ready && !w_redirect;
    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req_valid  = (r_state == FS_RUN) && fetch_en && !w_redirect && !w_fifo_full &&
                          (w_credit_sum < CREDIT_MAX);
    assign w_accept     = w_req_valid && imem_req_ready;
    assign w_outstanding_d = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
    assign w_drop_next  = r_drop_cnt - CW'(w_dropping);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= FS_IDLE;
            r_pc          <= RESET_PC;
            r_pc_tag      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_d;
            if (w_redirect) begin
                r_pc       <= w_target;
                r_pc_tag   <= w_target;
                r_drop_cnt <= w_outstanding_d;
                r_state    <= (w_outstanding_d != '0) ? FS_DRAIN : FS_RUN;
            end else begin
                if (w_accept) r_pc <= r_pc + INSTR_BYTES;
                if (w_push)   r_pc_tag <= r_pc_tag + INSTR_BYTES;
                r_drop_cnt <= w_drop_next;
                case (r_state)
                    FS_IDLE:  if (fetch_en) r_state <= FS_RUN;
                    FS_RUN:   if (!fetch_en && r_outstanding == '0) r_state <= FS_IDLE;
                    FS_DRAIN: if (w_drop_next == '0) r_state <= FS_RUN;
                    default:  r_state <= FS_IDLE;
                endcase
            end
        end
    end

    fetch_unit_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_pc_tag, imem_rsp_data}),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign if_valid       = !w_fifo_empty;
    assign if_instr       = w_fifo_empty ? 32'h0 : w_fifo_head[31:0];
    assign if_pc          = w_fifo_empty ? 32'h0 : w_fifo_head[63:32];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetched;
    logic [31:0] r_squashed;
    logic [31:0] w_squash_inc;

    always_comb begin
        w_squash_inc = 32'(w_dropping);
        if (w_redirect) begin
            w_squash_inc = w_squash_inc + 32'(w_fifo_count) + 32'(imem_rsp_valid && !w_dropping);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetched  <= '0;
            r_squashed <= '0;
        end else begin
            r_fetched  <= sat_add(r_fetched, 32'(w_pop));
            r_squashed <= sat_add(r_squashed, w_squash_inc);
        end
    end

    assign perf_fetched  = r_fetched;
    assign perf_squashed = r_squashed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus expected-PC stream model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    bit          o_req, o_acc, o_deliv, o_rsp;
    logic [31:0] o_addr, o_pc, o_instr;
    int          o_out_before;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: called at a negedge, applies inputs, samples, advances to next negedge.
    task automatic step(input bit en, input bit idr, input bit rv, input logic [31:0] rpc,
                        input bit rr);
        fetch_en       = en;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rr;
        o_out_before   = pend_addr.size();
        o_rsp          = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            o_rsp = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        o_req   = imem_req_valid;
        o_addr  = imem_req_addr;
        o_acc   = imem_req_valid && rr;
        o_deliv = if_valid && idr && !rv;
        o_pc    = if_pc;
        o_instr = if_instr;
        if (o_acc) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (imem_req_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_vec++; if (imem_req_addr !== RESET_PC) begin n_err++;
            $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
        n_vec++; if (if_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        n_vec++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin n_err++;
            $display("FAIL reset_if_data: got instr %h pc %h want 0 0", if_instr, if_pc); end
`ifdef FETCH_PERF_CNT_EN
        n_vec++; if (perf_fetched !== 32'h0 || perf_squashed !== 32'h0) begin n_err++;
            $display("FAIL reset_perf: got %h %h want 0 0", perf_fetched, perf_squashed); end
`endif
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        cyc    = 0;
    endtask

    task automatic test_stream;
        int got = 0;
        int first = -1;
        lat = 1;
        for (int i = 0; i < 60; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_req) begin
                n_vec++; if (o_out_before >= FIFO_DEPTH) begin n_err++;
                    $display("FAIL stream_credit: got outstanding %0d want < %0d",
                             o_out_before, FIFO_DEPTH); end
            end
            if (o_deliv) begin
                if (first < 0) first = i;
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL stream_word: got %h/%h want %h/%h", o_pc, o_instr,
                             exp_pc, mem_word(exp_pc)); end
                exp_pc += 32'd4;
                got++;
            end
        end
        n_vec++; if (first != 3) begin n_err++;
            $display("FAIL stream_first_cycle: got %0d want 3", first); end
        n_vec++; if (got < 20) begin n_err++;
            $display("FAIL stream_progress: got %0d words want >= 20", got); end
    endtask

    task automatic test_backpressure;
        int acc = 0;
        int got = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 32'h0, 1);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL drain_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        n_vec++; if (pend_addr.size() != 0 || if_valid !== 1'b0) begin n_err++;
            $display("FAIL drain_idle: got pend %0d if_valid %b want 0 0",
                     pend_addr.size(), if_valid); end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 32'h0, 1);
            if (o_acc) acc++;
        end
        n_vec++; if (acc != FIFO_DEPTH) begin n_err++;
            $display("FAIL stall_req_count: got %0d want %0d", acc, FIFO_DEPTH); end
        n_vec++; if (o_req !== 1'b0) begin n_err++;
            $display("FAIL stall_req_off: got %b want 0", o_req); end
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL release_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
                got++;
            end
        end
        n_vec++; if (got < FIFO_DEPTH) begin n_err++;
            $display("FAIL release_progress: got %0d want >= %0d", got, FIFO_DEPTH); end
    endtask

    task automatic test_redirect_drain;
        int stale;
        int got = 0;
        bit busy;
        lat = 3;
        for (int i = 0; i < 40 && pend_addr.size() != 2; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc) begin n_err++;
                    $display("FAIL pre_redirect_pc: got %h want %h", o_pc, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        n_vec++; if (pend_addr.size() != 2) begin n_err++;
            $display("FAIL redirect_setup: got %0d outstanding want 2", pend_addr.size()); end
        step(1, 1, 1, 32'h0000_0100, 1);
        n_vec++; if (o_req !== 1'b0) begin n_err++;
            $display("FAIL redirect_withdraw: got req %b want 0", o_req); end
        exp_pc = 32'h0000_0100;
        stale  = pend_addr.size();
        for (int i = 0; i < 40; i++) begin
            busy = (stale > 0);
            step(1, 1, 0, 32'h0, 1);
            if (busy) begin
                n_vec++; if (o_req !== 1'b0) begin n_err++;
                    $display("FAIL drain_no_req: got req %b want 0", o_req); end
            end
            if (o_rsp && stale > 0) stale--;
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL redirect_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
                got++;
            end
        end
        n_vec++; if (got == 0) begin n_err++;
            $display("FAIL redirect_timeout: got 0 words want > 0"); end
    endtask

    task automatic test_squash_pop;
        int got = 0;
        lat = 1;
        for (int i = 0; i < 20 && !if_valid; i++) step(1, 0, 0, 32'h0, 1);
        n_vec++; if (if_valid !== 1'b1) begin n_err++;
            $display("FAIL squash_setup: got if_valid %b want 1", if_valid); end
        step(1, 1, 1, 32'h0000_2000, 1);
        exp_pc = 32'h0000_2000;
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL squash_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
                got++;
            end
        end
        n_vec++; if (got == 0) begin n_err++;
            $display("FAIL squash_timeout: got 0 words want > 0"); end
    endtask

    task automatic test_stall_wrap;
        logic [31:0] accs [$];
        lat = 2;
        step(1, 1, 1, 32'hFFFF_FFFC, 1);
        exp_pc = 32'hFFFF_FFFC;
        o_req = 1'b0;
        for (int i = 0; i < 30 && !o_req; i++) step(1, 0, 0, 32'h0, 0);
        n_vec++; if (o_req !== 1'b1) begin n_err++;
            $display("FAIL wrap_req_timeout: got %b want 1", o_req); end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 32'h0, 0);
            n_vec++; if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin n_err++;
                $display("FAIL stall_hold: got %b/%h want 1/fffffffc", o_req, o_addr); end
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_acc) accs.push_back(o_addr);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL wrap_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
            end
        end
        n_vec++; if (accs.size() < 2 || accs[0] !== 32'hFFFF_FFFC || accs[1] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_addr: got %0d accepts first %h want fffffffc then 0",
                     accs.size(), (accs.size() > 0) ? accs[0] : 32'hx); end
    endtask

    task automatic test_reset_mid;
        int got = 0;
        lat = 1;
        for (int i = 0; i < 20 && !if_valid; i++) step(1, 0, 0, 32'h0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin n_err++;
            $display("FAIL midreset_valid: got %b/%b want 0/0", imem_req_valid, if_valid); end
        n_vec++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || imem_req_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL midreset_data: got %h/%h/%h want 0/0/%h", if_instr, if_pc,
                     imem_req_addr, RESET_PC); end
`ifdef FETCH_PERF_CNT_EN
        n_vec++; if (perf_fetched !== 32'h0 || perf_squashed !== 32'h0) begin n_err++;
            $display("FAIL midreset_perf: got %h %h want 0 0", perf_fetched, perf_squashed); end
`endif
        imem_rsp_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = RESET_PC;
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 32'h0, 1);
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL restart_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
                got++;
            end
        end
        n_vec++; if (got == 0) begin n_err++;
            $display("FAIL restart_timeout: got 0 words want > 0"); end
    endtask

    task automatic test_random;
        bit          rv, idr, rr;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            lat = $urandom_range(1, 4);
            idr = ($urandom_range(0, 99) < 70);
            rr  = ($urandom_range(0, 99) < 75);
            rv  = ($urandom_range(0, 99) < 4);
            rpc = $urandom & 32'h0003_FFFF;
            step(1, idr, rv, rpc, rr);
            if (o_req) begin
                n_vec++; if (o_out_before >= FIFO_DEPTH) begin n_err++;
                    $display("FAIL rand_credit: got outstanding %0d want < %0d",
                             o_out_before, FIFO_DEPTH); end
            end
            if (rv) begin
                n_vec++; if (o_req !== 1'b0) begin n_err++;
                    $display("FAIL rand_withdraw: got req %b want 0", o_req); end
                exp_pc = rpc & 32'hFFFF_FFFC;
            end
            if (o_deliv) begin
                n_vec++; if (o_pc !== exp_pc || o_instr !== mem_word(exp_pc)) begin n_err++;
                    $display("FAIL rand_word: got %h/%h want %h", o_pc, o_instr, exp_pc); end
                exp_pc += 32'd4;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_squash_pop();
        test_stall_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
